noc_node_injector: RTL
======================

NOC_NODE_INJECTOR -- requirements
Module: noc_node_injector

Interface
REQ-001 The block SHALL have parameter NODE_COUNT, default 49, meaning the number of routers in the circulant; valid destinations are 0..NODE_COUNT-1.
REQ-002 The block SHALL have parameter GAP, default 5, meaning the number of idle cycles forced after each injected packet (diameter 4 + 1).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of request queue entries (power of two).
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 router_name  input  6  number of the attached router, static.
REQ-007 req_valid  input  1  host request to send one packet.
REQ-008 req_dest  input  6  destination router number.
REQ-009 req_ready  output  1  queue can accept, combinational = not full.
REQ-010 pkt_out  output  13  drives the router in_free port: bit12 valid, bits11:6 zero, bits5:0 destination.
REQ-011 delivered  input  1  router out_data, one-cycle pulse per packet terminating at this node.
REQ-012 err_dest  output  1  one-cycle pulse for a rejected request.
REQ-013 tx_busy  output  1  high while FIFO non-empty or FSM not IDLE.
REQ-014 tx_count  output  16  packets injected.
REQ-015 rx_count  output  16  delivered pulses counted.

Function
REQ-016 The block SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-017 An accepted request with req_dest < NODE_COUNT SHALL be pushed into the FIFO.
REQ-018 An accepted request with req_dest >= NODE_COUNT SHALL NOT be queued, and err_dest SHALL be 1 for exactly the following cycle.
REQ-019 req_dest == router_name SHALL be treated as a valid request and injected normally.
REQ-020 When the FIFO is full, req_ready SHALL be 0 and req_valid SHALL be ignored, even in a cycle where a pop occurs.
REQ-021 The FSM SHALL have states IDLE and GAP_WAIT.
REQ-022 In IDLE with the FIFO non-empty, the next edge SHALL pop the head, register pkt_out = {1'b1, 6'b0, dest}, increment tx_count, and enter GAP_WAIT with gap counter = GAP.
REQ-023 pkt_out SHALL be non-zero for exactly one cycle per packet and SHALL be 13'b0 in all other cycles.
REQ-024 In GAP_WAIT the gap counter SHALL decrement each cycle; on reaching 0 the FSM SHALL return to IDLE.
REQ-025 Result of REQ-022 to REQ-024: consecutive pkt_out-valid cycles SHALL be exactly GAP+1 clocks apart while the FIFO stays non-empty, i.e. GAP zero cycles between packets.
REQ-026 Injection latency SHALL be as follows: a request accepted at edge E into an empty FIFO with the FSM in IDLE SHALL produce pkt_out valid in the cycle after edge E+1.
REQ-027 A push and a pop in the same cycle SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 rx_count SHALL increment on every cycle with delivered=1, independent of the TX state.
REQ-030 tx_count and rx_count SHALL saturate at 16'hFFFF.
REQ-031 err_dest and tx_busy SHALL be registered outputs.

Reset
REQ-032 While rst=1 at an edge, the block SHALL do all of the following:
- flush the FIFO;
- set the FSM to IDLE and the gap counter to 0;
- set pkt_out=0, err_dest=0, tx_busy=0, tx_count=0, rx_count=0.
REQ-033 Reset asserted mid-GAP_WAIT or with a queued request SHALL discard all pending requests; no packet SHALL appear after reset release without a new request.
REQ-034 req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-035 Single send: router_name=0, request dest=17 -> pkt_out=13'h1011 for one cycle, two cycles after acceptance; tx_count=1.
REQ-036 Burst pacing: 4 back-to-back requests dest=1,2,3,4 -> four pkt_out pulses in order, each 6 clocks apart; req_ready drops only when 4 entries are queued.
REQ-037 Invalid destination: dest=49 and dest=63 -> err_dest pulses, no pkt_out, tx_count unchanged.
REQ-038 Full FIFO with simultaneous pop: 5th request held while full -> accepted only after the first pop; no entry lost or duplicated.
REQ-039 Receive: 3 delivered pulses interleaved with TX -> rx_count=3; with rx_count preloaded to 16'hFFFF, one further pulse -> stays 16'hFFFF.
REQ-040 Mid-operation reset: rst asserted during GAP_WAIT with 2 queued requests -> all outputs zero, and no pkt_out for 10 cycles after release.

Source files
------------

// File: rtl/noc_node_injector.sv
// Host-side packet injector for one circulant NoC router: queues destination requests and
// injects them one at a time, leaving enough idle cycles for each packet to clear the network.
module noc_node_injector #(
    parameter int unsigned NODE_COUNT = 49,
    parameter int unsigned GAP        = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  router_name,
    input  logic        req_valid,
    input  logic [5:0]  req_dest,
    output logic        req_ready,
    output logic [12:0] pkt_out,
    input  logic        delivered,
    output logic        err_dest,
    output logic        tx_busy,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    localparam int unsigned PtrW  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned GapW  = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [6:0]  DestLimit = 7'(NODE_COUNT);

    typedef enum logic [0:0] {StIdle, StGapWait} state_e;

    state_e            state_q;
    logic [GapW-1:0]   gap_q;
    logic [5:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [12:0]       pkt_q;
    logic              err_q, busy_q;
    logic [15:0]       tx_count_q, rx_count_q;

    logic accept, dest_ok, push, pop, busy_d;

    // Self-addressed packets are injected like any other, so the router number is not needed.
    logic unused_router_name;
    assign unused_router_name = ^router_name;

    assign req_ready = (count_q != CntW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign dest_ok   = ({1'b0, req_dest} < DestLimit);
    assign push      = accept && dest_ok;
    assign pop       = (state_q == StIdle) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Busy reflects the state after this edge so the registered flag tracks queue and FSM.
    always_comb begin
        busy_d = (count_d != '0);
        if (state_q == StIdle) begin
            if (pop && (GAP != 0)) busy_d = 1'b1;
        end else if (gap_q > GapW'(1)) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_dest;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            err_q   <= accept && !dest_ok;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            pkt_q      <= '0;
            tx_count_q <= '0;
        end else begin
            pkt_q <= '0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        pkt_q <= {1'b1, 6'b0, mem_q[rd_ptr_q]};
                        if (tx_count_q != 16'hFFFF) tx_count_q <= tx_count_q + 16'd1;
                        if (GAP != 0) begin
                            state_q <= StGapWait;
                            gap_q   <= GapW'(GAP);
                        end
                    end
                end
                StGapWait: begin
                    gap_q <= gap_q - GapW'(1);
                    if (gap_q <= GapW'(1)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_q <= '0;
        end else if (delivered && (rx_count_q != 16'hFFFF)) begin
            rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign pkt_out  = pkt_q;
    assign err_dest = err_q;
    assign tx_busy  = busy_q;
    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;

endmodule
